// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature bridge: read-FSM states,
// counter width helper and the shift/saturate requantiser.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DRAIN
  } rd_state_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic right shift followed by saturation to a signed out_bits range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] value,
    input int                 shift,
    input int                 out_bits
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = value >>> shift;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/bridge_requant.sv
// One output lane of the feature bridge: shift and saturate a stored value,
// or emit zero for an entry that was never written in this frame.
module bridge_requant
  import cnn_pkg::*;
#(
  parameter int BitSize    = 32,
  parameter int OutBitSize = 16,
  parameter int Shift      = 4
) (
  input  logic [BitSize-1:0]    in_value,
  input  logic                  written,
  output logic [OutBitSize-1:0] out_value
);

  always_comb begin
    out_value = '0;
    if (written) begin
      out_value = OutBitSize'(sat_shift(64'(signed'(in_value)), Shift, OutBitSize));
    end
  end

endmodule

// File: rtl/feature_bridge.sv
// Ping-pong frame buffer between the conv/pool pipeline and the dense layers:
// captures NumIn values per beat, optionally flattens channel-major, requantises
// and streams NumOut values per beat under valid/ready backpressure.
module feature_bridge
  import cnn_pkg::*;
#(
  parameter int BitSize    = 32,
  parameter int OutBitSize = 16,
  parameter int NumIn      = 4,
  parameter int NumOut     = 2,
  parameter int NumCh      = 8,
  parameter int ImageSize  = 4,
  parameter int Shift      = 4,
  parameter int Transpose  = 1
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         in_valid,
  input  logic [NumIn*BitSize-1:0]     in_data,
  input  logic                         in_set_done,
  input  logic                         in_ready,
  output logic                         out_ready,
  output logic [NumOut*OutBitSize-1:0] out_data,
  output logic                         out_valid,
  output logic                         out_done,
  output logic                         out_overflow
);

  localparam int FrameLen = NumCh * ImageSize;
  localparam int WBeats   = FrameLen / NumIn;
  localparam int RBeats   = FrameLen / NumOut;
  localparam int SW       = cnt_width(FrameLen);
  localparam int WW       = cnt_width(WBeats);
  localparam int RW       = cnt_width(RBeats);
  localparam int KW       = cnt_width(NumCh + 1);
  localparam int PW       = cnt_width(ImageSize);
  localparam int StepP    = NumOut % ImageSize;
  localparam int StepK    = NumOut / ImageSize;

  if ((FrameLen % NumIn) != 0 || (FrameLen % NumOut) != 0) begin : g_bad_frame
    $error("feature_bridge: NumCh*ImageSize must be a multiple of NumIn and NumOut");
  end

  logic [BitSize-1:0]         mem_reg     [2][FrameLen];
  logic [FrameLen-1:0]        written_reg [2];
  logic [1:0]                 full_reg;
  logic                       wbank_reg;
  logic                       rbank_reg;
  logic [WW-1:0]              wcnt_reg;
  logic [RW-1:0]              rcnt_reg;
  logic [KW-1:0]              ld_k_reg;
  logic [PW-1:0]              ld_p_reg;
  logic [KW-1:0]              ld_k_next;
  logic [PW-1:0]              ld_p_next;
  logic [NumOut*OutBitSize-1:0] out_data_reg;
  logic                       overflow_reg;
  rd_state_t                  state_reg;
  rd_state_t                  state_next;
  logic                       load_beat;
  logic                       drain;
  logic                       accept;
  logic                       close;
  logic [OutBitSize-1:0]      lane_q [NumOut];

  assign out_ready    = !full_reg[wbank_reg];
  assign accept       = in_valid && out_ready;
  assign close        = accept && (in_set_done || wcnt_reg == WW'(WBeats - 1));
  assign out_valid    = (state_reg == SEND);
  assign out_done     = (state_reg == DRAIN);
  assign out_overflow = overflow_reg;
  assign out_data     = out_data_reg;

  // Read FSM: LOAD fills the output register, SEND reloads on every handshake.
  always_comb begin
    state_next = state_reg;
    load_beat  = 1'b0;
    drain      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (full_reg[rbank_reg]) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_beat  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (in_ready) begin
          if (rcnt_reg == RW'(RBeats - 1)) begin
            state_next = DRAIN;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      DRAIN: begin
        drain      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The load pointer tracks (channel k, pixel p) of the next beat's first value.
  always_comb begin
    int np;
    int nk;
    np = int'(ld_p_reg) + StepP;
    nk = int'(ld_k_reg) + StepK;
    if (np >= ImageSize) begin
      np = np - ImageSize;
      nk = nk + 1;
    end
    ld_p_next = PW'(np);
    ld_k_next = KW'(nk);
  end

  genvar gi;
  for (gi = 0; gi < NumOut; gi++) begin : g_lane
    localparam int LaneP = gi % ImageSize;
    localparam int LaneK = gi / ImageSize;
    int          p_i;
    int          k_i;
    logic [SW-1:0] src;

    always_comb begin
      p_i = int'(ld_p_reg) + LaneP;
      k_i = int'(ld_k_reg) + LaneK;
      if (p_i >= ImageSize) begin
        p_i = p_i - ImageSize;
        k_i = k_i + 1;
      end
      if (Transpose != 0) begin
        src = SW'(p_i * NumCh + k_i);
      end else begin
        src = SW'(k_i * ImageSize + p_i);
      end
    end

    bridge_requant #(
      .BitSize   (BitSize),
      .OutBitSize(OutBitSize),
      .Shift     (Shift)
    ) u_requant (
      .in_value (mem_reg[rbank_reg][src]),
      .written  (written_reg[rbank_reg][src]),
      .out_value(lane_q[gi])
    );
  end

  // Frame storage; the writer and the draining reader always own different banks.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int b = 0; b < 2; b++) begin
        written_reg[b] <= '0;
      end
    end else begin
      if (drain) begin
        written_reg[rbank_reg] <= '0;
      end
      if (accept) begin
        for (int l = 0; l < NumIn; l++) begin
          mem_reg[wbank_reg][SW'(int'(wcnt_reg) * NumIn + l)]     <= in_data[l*BitSize +: BitSize];
          written_reg[wbank_reg][SW'(int'(wcnt_reg) * NumIn + l)] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg    <= IDLE;
      full_reg     <= '0;
      wbank_reg    <= 1'b0;
      rbank_reg    <= 1'b0;
      wcnt_reg     <= '0;
      rcnt_reg     <= '0;
      ld_k_reg     <= '0;
      ld_p_reg     <= '0;
      out_data_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (in_valid && !out_ready) begin
        overflow_reg <= 1'b1;
      end
      if (close) begin
        full_reg[wbank_reg] <= 1'b1;
        wbank_reg           <= ~wbank_reg;
        wcnt_reg            <= '0;
      end else if (accept) begin
        wcnt_reg <= wcnt_reg + WW'(1);
      end
      if (drain) begin
        full_reg[rbank_reg] <= 1'b0;
        rbank_reg           <= ~rbank_reg;
        rcnt_reg            <= '0;
        ld_k_reg            <= '0;
        ld_p_reg            <= '0;
      end
      if (load_beat) begin
        for (int l = 0; l < NumOut; l++) begin
          out_data_reg[l*OutBitSize +: OutBitSize] <= lane_q[l];
        end
        ld_k_reg <= ld_k_next;
        ld_p_reg <= ld_p_next;
        if (state_reg == SEND) begin
          rcnt_reg <= rcnt_reg + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_feature_bridge.sv
// Scoreboard bench for feature_bridge: dut 0 is arrival order with no shift,
// dut 1 is channel-major with Shift=4; only one of them streams at a time.
module tb_feature_bridge;

  logic         clk;
  logic         res;
  logic         in_valid    [2];
  logic [127:0] in_data     [2];
  logic         in_set_done [2];
  logic         in_ready    [2];
  logic         out_ready   [2];
  logic [31:0]  out_data    [2];
  logic         out_valid   [2];
  logic         out_done    [2];
  logic         out_overflow[2];

  typedef struct {
    int          dut;
    logic [31:0] data;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  bit          done_due[2];
  int          total;
  int          bad;
  logic [31:0] vin  [32];
  logic [15:0] vexp [32];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    feature_bridge #(
      .BitSize   (32),
      .OutBitSize(16),
      .NumIn     (4),
      .NumOut    (2),
      .NumCh     (8),
      .ImageSize (4),
      .Shift     (gi == 0 ? 0 : 4),
      .Transpose (gi == 0 ? 0 : 1)
    ) dut (
      .clk         (clk),
      .res         (res),
      .in_valid    (in_valid[gi]),
      .in_data     (in_data[gi]),
      .in_set_done (in_set_done[gi]),
      .in_ready    (in_ready[gi]),
      .out_ready   (out_ready[gi]),
      .out_data    (out_data[gi]),
      .out_valid   (out_valid[gi]),
      .out_done    (out_done[gi]),
      .out_overflow(out_overflow[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %08h, required %08h", name, d, act, exp);
    end
  endtask

  task automatic push_frame(input int d, input logic [15:0] v [32]);
    for (int b = 0; b < 16; b++) begin
      exp_q.push_back('{d, {v[2*b+1], v[2*b]}, (b == 15)});
    end
  endtask

  task automatic send_frame(input int d, input logic [31:0] vals [32], input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk);
      #1;
      in_valid[d]    = 1'b1;
      in_data[d]     = {vals[4*b+3], vals[4*b+2], vals[4*b+1], vals[4*b]};
      in_set_done[d] = (b == nbeats - 1) && (nbeats < 8);
    end
    @(posedge clk);
    #1;
    in_valid[d]    = 1'b0;
    in_set_done[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_due[0] || done_due[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: every handshake pops one expected beat; out_done must follow the last.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_due[d]) begin
        check("done_pulse", d, 32'(out_done[d]), 32'd1);
        done_due[d] = 1'b0;
      end else if (out_done[d]) begin
        check("done_spurious", d, 32'(out_done[d]), 32'd0);
      end
      if (!res && out_valid[d] && in_ready[d]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat dut%0d: got %08h, required no beat", d, out_data[d]);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_dut", d, 32'(d), 32'(mon_e.dut));
          check("beat_data", d, out_data[d], mon_e.data);
          $display("beat dut%0d data=%08h expected=%08h last=%0d", d, out_data[d], mon_e.data, mon_e.last);
          if (mon_e.last) begin
            done_due[d] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    res   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]    = 1'b0;
      in_data[d]     = '0;
      in_set_done[d] = 1'b0;
      in_ready[d]    = 1'b1;
      done_due[d]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_out_ready", d, 32'(out_ready[d]), 32'd1);
      check("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
      check("rst_out_done", d, 32'(out_done[d]), 32'd0);
      check("rst_overflow", d, 32'(out_overflow[d]), 32'd0);
      check("rst_out_data", d, out_data[d], 32'd0);
    end

    // Arrival order, values 0..31, plus close-to-first-valid latency.
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(i);
      vexp[i] = 16'(i);
    end
    push_frame(0, vexp);
    send_frame(0, vin, 8);
    @(negedge clk);
    @(negedge clk);
    check("latency_load", 0, 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    check("latency_first", 0, 32'(out_valid[0]), 32'd1);
    wait_drain();

    // Channel-major: inputs i*16 shifted back to i, read as 0,8,16,24,1,9,...
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(i * 16);
      vexp[i] = 16'((i % 4) * 8 + i / 4);
    end
    push_frame(1, vexp);
    send_frame(1, vin, 8);
    wait_drain();

    // Saturation on a one-beat frame; sources 0..3 land at outputs 0,4,8,12.
    for (int i = 0; i < 32; i++) begin
      vin[i]  = '0;
      vexp[i] = '0;
    end
    vin[0]   = 32'h7FFF_FFFF;
    vin[1]   = 32'h8000_0000;
    vin[2]   = 32'h0000_0120;
    vin[3]   = 32'hFFFF_FFE0;
    vexp[0]  = 16'h7FFF;
    vexp[4]  = 16'h8000;
    vexp[8]  = 16'd18;
    vexp[12] = 16'hFFFE;
    push_frame(1, vexp);
    send_frame(1, vin, 1);
    wait_drain();

    // Early close after 12 values, then a full frame starting again at index 0.
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(i);
      vexp[i] = (i < 12) ? 16'(i) : 16'd0;
    end
    push_frame(0, vexp);
    send_frame(0, vin, 3);
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(100 + i);
      vexp[i] = 16'(100 + i);
    end
    push_frame(0, vexp);
    send_frame(0, vin, 8);
    wait_drain();

    // Backpressure with both banks full; a dropped beat must not corrupt frame 2.
    @(posedge clk);
    #1;
    in_ready[0] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(200 + i);
      vexp[i] = 16'(200 + i);
    end
    push_frame(0, vexp);
    send_frame(0, vin, 8);
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(300 + i);
      vexp[i] = 16'(300 + i);
    end
    push_frame(0, vexp);
    send_frame(0, vin, 8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 0, 32'(out_valid[0]), 32'd1);
      check("hold_data", 0, out_data[0], {16'd201, 16'd200});
      check("hold_ready", 0, 32'(out_ready[0]), 32'd0);
      if (i == 5) begin
        in_valid[0]    = 1'b1;
        in_data[0]     = {4{32'hDEAD_BEEF}};
        in_set_done[0] = 1'b1;
      end
      if (i == 6) begin
        in_valid[0]    = 1'b0;
        in_set_done[0] = 1'b0;
      end
    end
    check("overflow_set", 0, 32'(out_overflow[0]), 32'd1);
    @(posedge clk);
    #1;
    in_ready[0] = 1'b1;
    wait_drain();
    check("overflow_sticky", 0, 32'(out_overflow[0]), 32'd1);

    // Reset while stalled in SEND with the other bank pending.
    @(posedge clk);
    #1;
    in_ready[0] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      vin[i] = 32'(400 + i);
    end
    send_frame(0, vin, 8);
    send_frame(0, vin, 4);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_in_send", 0, 32'(out_valid[0]), 32'd1);
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 0, 32'(out_valid[0]), 32'd0);
    check("mid_rst_ready", 0, 32'(out_ready[0]), 32'd1);
    check("mid_rst_overflow", 0, 32'(out_overflow[0]), 32'd0);
    check("mid_rst_data", 0, out_data[0], 32'd0);
    @(posedge clk);
    #1;
    in_ready[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_idle", 0, 32'(out_valid[0]), 32'd0);
    for (int i = 0; i < 32; i++) begin
      vin[i]  = 32'(600 + i);
      vexp[i] = 16'(600 + i);
    end
    push_frame(0, vexp);
    send_frame(0, vin, 8);
    wait_drain();

    check("queue_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feature_bridge.md
Name: feature_bridge

Overview:
- Parametrised, buffered successor to the bare register stage between the conv/pooling pipeline and the dense layers in the CNN top.
- Captures one feature-map frame (NumCh channels × ImageSize pixels) arriving NumIn lanes per beat, into a ping-pong register buffer.
- Optionally transposes pixel-major input to channel-major (flatten) order and requantises each value to OutBitSize with shift and saturation.
- Streams the frame NumOut values per beat to the DNN under valid/ready backpressure, and signals frame completion.

Parameters:
BitSize, 32, input value width (signed)
OutBitSize, 16, output value width (signed)
NumIn, 4, input lanes per beat
NumOut, 2, output lanes per beat
NumCh, 8, channels per frame
ImageSize, 4, pixels per channel
Shift, 4, arithmetic right shift applied before saturation (0..BitSize-1)
Transpose, 1, 0: output in arrival order; 1: channel-major order (index k*ImageSize+p)
Derived: FrameLen = NumCh*ImageSize. Elaboration error unless FrameLen%NumIn==0 and FrameLen%NumOut==0.

Ports:
clk  in  1  clock
res  in  1  reset; one clock, reset is synchronous and active-high
in_valid  in  1  input beat valid
in_data  in  NumIn×BitSize  lanes, lane 0 = lowest index
in_set_done  in  1  end-of-frame marker, qualified by in_valid, same beat as last data
in_ready  in  1  downstream (DNN) ready
out_ready  out  1  bridge can accept an input beat
out_data  out  NumOut×OutBitSize  output lanes
out_valid  out  1  output beat valid
out_done  out  1  one-cycle pulse: a frame has fully drained
out_overflow  out  1  sticky: input beat arrived while out_ready=0

Behaviour:
- Reset (res=1 at a clock edge): both banks empty, all written bits cleared, write/read counters 0, wbank=rbank=0. Outputs: out_ready=1, out_valid=0, out_done=0, out_overflow=0, out_data=0. Reset mid-frame discards both banks.
- Write side: out_ready = !full[wbank]. An accepted beat (in_valid&&out_ready) stores lane l at index wcnt*NumIn+l and sets its written bit; wcnt increments.
- Frame close: on the accepted beat where wcnt==FrameLen/NumIn-1 or in_set_done=1, set full[wbank], toggle wbank, set wcnt=0. An early close leaves unwritten entries with written=0.
- in_set_done with in_valid=0 is ignored.
- in_valid while out_ready=0: data is dropped, out_overflow is set, state is otherwise unchanged.
- Read FSM states:
  - IDLE → LOAD when full[rbank].
  - LOAD: register beat rcnt into out_data; out_valid=1 next cycle.
  - SEND: hold out_data/out_valid stable until in_ready. On handshake, if rcnt==FrameLen/NumOut-1 → DRAIN, else rcnt++ and the next beat is registered in the same cycle (back-to-back, 1 beat/cycle while in_ready=1).
  - DRAIN: clear full[rbank] and its written bits, pulse out_done, toggle rbank, return to IDLE. out_valid=0 in this cycle.
- Latency: frame close → first out_valid = 2 cycles.
- Simultaneous events: the writer may close a frame into bank A in the same cycle the reader releases bank B. Both take effect, and out_ready is 1 the next cycle.
- Read order: output index j. Transpose=0: source index j. Transpose=1: k=j/ImageSize, p=j%ImageSize, source = p*NumCh+k. Implemented with k/p counters, no dividers.
- Requantise per lane: v = written ? (in >>> Shift) : 0. If v > 2^(OutBitSize-1)-1 the result is that maximum; if v < -2^(OutBitSize-1) the result is that minimum; otherwise truncate to OutBitSize.
- Storage: 2×FrameLen×BitSize flops plus 2×FrameLen written bits. Reads are combinational multiplexers into the output register.

Decomposition:
- Shared package cnn_pkg:
  - read-FSM state enum (IDLE, LOAD, SEND, DRAIN)
  - function sat_shift(value, Shift, OutBitSize)
  - function clog2-based counter widths
- One natural sub-module: bridge_requant (one lane: arithmetic shift + saturation, combinational), instantiated NumOut times.

Test Plan:
- Default params, Transpose=0, Shift=0. Feed 8 beats with values 0..31 → 16 output beats of (0,1),(2,3)…(30,31); out_done pulses once, 1 cycle after the last handshake.
- Transpose=1, same input → output sequence 0,8,16,24,1,9,17,25,…,7,15,23,31.
- Shift=4, inputs 0x7FFFFFFF, 0x80000000, 0x00000120, 0xFFFFFFE0 → outputs 32767, -32768, 18, -2.
- Early in_set_done on beat 3 (12 values written), Transpose=0 → 16 output beats; values 12..31 read 0; next frame starts at index 0.
- Hold in_ready=0 for 20 cycles with both banks full: out_data/out_valid stay stable, out_ready=0. An in_valid during that window sets out_overflow, and the frame contents are unchanged.
- Assert res for 1 cycle while in SEND with one bank pending → next cycle: out_valid=0, out_ready=1, out_overflow=0; a following frame streams correctly.
